// File: rtl/reg_bank_pc_unit.sv
// Register bank (R0=PC, R1=SP, R2=SR, R3=constant generator) with PC staging/commit
// and edge-triggered write-back, driven by the control unit's level-held strobes.
module reg_bank_pc_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] RESET_SP = 16'h0400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_pc_2,
  input  logic        branch_en,
  input  logic [9:0]  pc_offset,
  input  logic        pc_inc,
  input  logic [3:0]  src_reg,
  input  logic [3:0]  dst_reg,
  input  logic [3:0]  wr_reg,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        flag_we,
  input  logic [3:0]  flags_in,
  output logic [15:0] src_data,
  output logic [15:0] dst_data,
  output logic [15:0] pc,
  output logic [15:0] pc_staged,
  output logic        pc_update,
  output logic        wr_ack,
  output logic        pc_err
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OFF_W  = 10;
  localparam logic [3:0]  REG_PC = 4'd0;
  localparam logic [3:0]  REG_SP = 4'd1;
  localparam logic [3:0]  REG_SR = 4'd2;
  localparam logic [3:0]  REG_CG = 4'd3;

  typedef enum logic [0:0] {IDLE = 1'b0, STAGED = 1'b1} pc_state_t;

  pc_state_t          state, state_nxt;
  logic [DATA_W-1:0]  regs [16];
  logic               en_pc_2_q, pc_inc_q, wr_en_q;
  logic               stage_rise, inc_rise, wr_rise;
  logic               commit_c, err_set_c;
  logic               wr_r0_c, wr_allowed_c;
  logic [DATA_W-1:0]  wr_val_c, pc_plus2_c, branch_off_c, stage_val_c;

  assign stage_rise = en_pc_2 & ~en_pc_2_q;
  assign inc_rise   = pc_inc & ~pc_inc_q;
  assign wr_rise    = wr_en & ~wr_en_q;

  // Next-PC candidates: PC+2, optionally plus the sign-extended word offset
  assign pc_plus2_c   = regs[REG_PC] + DATA_W'(2);
  assign branch_off_c = {{(DATA_W-OFF_W-1){pc_offset[OFF_W-1]}}, pc_offset, 1'b0};
  assign stage_val_c  = branch_en ? (pc_plus2_c + branch_off_c) : pc_plus2_c;

  // Write-back payload: R0/R1 are word aligned, R3 is never written
  assign wr_val_c     = ((wr_reg == REG_PC) || (wr_reg == REG_SP)) ? {wr_data[DATA_W-1:1], 1'b0}
                                                                   : wr_data;
  assign wr_allowed_c = wr_rise && (wr_reg != REG_CG);
  assign wr_r0_c      = wr_rise && (wr_reg == REG_PC);

  // Combinational reads without write bypass; R3 is the constant zero
  assign src_data = (src_reg == REG_CG) ? '0 : regs[src_reg];
  assign dst_data = (dst_reg == REG_CG) ? '0 : regs[dst_reg];
  assign pc       = regs[REG_PC];

  // PC FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // PC FSM next state: any stage rise (re)stages, a commit returns to IDLE
  always_comb begin
    state_nxt = state;
    if (stage_rise)                        state_nxt = STAGED;
    else if (inc_rise && state == STAGED)  state_nxt = IDLE;
  end

  // PC FSM outputs: a commit coinciding with a stage rise counts as a commit from IDLE
  always_comb begin
    commit_c  = 1'b0;
    err_set_c = 1'b0;
    if (inc_rise) begin
      if (state == STAGED && !stage_rise) commit_c  = 1'b1;
      else                                err_set_c = 1'b1;
    end
  end

  // Strobe history, staged PC and status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      en_pc_2_q <= 1'b0;
      pc_inc_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      pc_staged <= RESET_PC;
      pc_update <= 1'b0;
      wr_ack    <= 1'b0;
      pc_err    <= 1'b0;
    end else begin
      en_pc_2_q <= en_pc_2;
      pc_inc_q  <= pc_inc;
      wr_en_q   <= wr_en;
      if (stage_rise) pc_staged <= stage_val_c;
      pc_update <= commit_c && !wr_r0_c;
      wr_ack    <= wr_rise;
      if (err_set_c) pc_err <= 1'b1;
    end
  end

  // Register file: flags, then PC commit, then write-back (later assignments win)
  always_ff @(posedge clk) begin
    if (rst) begin
      regs         <= '{default: '0};
      regs[REG_PC] <= RESET_PC;
      regs[REG_SP] <= RESET_SP;
    end else begin
      if (flag_we) begin
        regs[REG_SR][8] <= flags_in[3];
        regs[REG_SR][2] <= flags_in[2];
        regs[REG_SR][1] <= flags_in[1];
        regs[REG_SR][0] <= flags_in[0];
      end
      if (commit_c)     regs[REG_PC] <= pc_staged;
      if (wr_allowed_c) regs[wr_reg] <= wr_val_c;
    end
  end

endmodule

// File: tb/tb_reg_bank_pc_unit.sv
// Scoreboard bench for reg_bank_pc_unit: expectations are queued when stimulus is
// driven and compared against the DUT outputs after the following clock edge.
module tb_reg_bank_pc_unit;

  localparam int SIG_PC   = 0;
  localparam int SIG_SRC  = 1;
  localparam int SIG_DST  = 2;
  localparam int SIG_UPD  = 3;
  localparam int SIG_ACK  = 4;
  localparam int SIG_ERR  = 5;
  localparam int SIG_STG  = 6;

  typedef struct {
    string       tag;
    int          sig;
    logic [15:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_pc_2, branch_en, pc_inc, wr_en, flag_we;
  logic [9:0]  pc_offset;
  logic [3:0]  src_reg, dst_reg, wr_reg, flags_in;
  logic [15:0] wr_data;
  logic [15:0] src_data, dst_data, pc, pc_staged;
  logic        pc_update, wr_ack, pc_err;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   upd_cnt = 0;
  int   ack_cnt = 0;
  logic [15:0] exp_pc;

  reg_bank_pc_unit dut (
    .clk(clk), .rst(rst), .en_pc_2(en_pc_2), .branch_en(branch_en),
    .pc_offset(pc_offset), .pc_inc(pc_inc), .src_reg(src_reg), .dst_reg(dst_reg),
    .wr_reg(wr_reg), .wr_en(wr_en), .wr_data(wr_data), .flag_we(flag_we),
    .flags_in(flags_in), .src_data(src_data), .dst_data(dst_data), .pc(pc),
    .pc_staged(pc_staged), .pc_update(pc_update), .wr_ack(wr_ack), .pc_err(pc_err)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (!rst && pc_update) upd_cnt++;
    if (!rst && wr_ack)    ack_cnt++;
  end

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] observe(input int sig);
    case (sig)
      SIG_PC:  return pc;
      SIG_SRC: return src_data;
      SIG_DST: return dst_data;
      SIG_UPD: return {15'd0, pc_update};
      SIG_ACK: return {15'd0, wr_ack};
      SIG_ERR: return {15'd0, pc_err};
      default: return pc_staged;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sig, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val(e.tag, observe(e.sig), e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    rst = 1'b1; en_pc_2 = 0; branch_en = 0; pc_offset = '0; pc_inc = 0;
    src_reg = 4'd1; dst_reg = 4'd5; wr_reg = '0; wr_en = 0; wr_data = '0;
    flag_we = 0; flags_in = '0;
    @(posedge clk); #1;
    expect_val("rst_pc", SIG_PC, 16'h0000);
    expect_val("rst_sp", SIG_SRC, 16'h0400);
    expect_val("rst_r5", SIG_DST, 16'h0000);
    expect_val("rst_upd", SIG_UPD, 16'h0);
    expect_val("rst_ack", SIG_ACK, 16'h0);
    expect_val("rst_err", SIG_ERR, 16'h0);
    step();
    rst = 1'b0;
    step();

    // Sequential advance: stage for one cycle, hold pc_inc for two
    exp_pc = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      en_pc_2 = 1'b1;
      expect_val("seq_stage", SIG_STG, exp_pc + 16'd2);
      step();
      en_pc_2 = 1'b0; pc_inc = 1'b1;
      exp_pc = exp_pc + 16'd2;
      expect_val("seq_pc", SIG_PC, exp_pc);
      expect_val("seq_upd", SIG_UPD, 16'h1);
      step();
      expect_val("seq_pc_hold", SIG_PC, exp_pc);
      expect_val("seq_upd_once", SIG_UPD, 16'h0);
      step();
      pc_inc = 1'b0;
      step();
    end

    // Load R0 with an odd value: bit0 is forced low
    wr_reg = 4'd0; wr_data = 16'h0011; wr_en = 1'b1;
    expect_val("r0_wr", SIG_PC, 16'h0010);
    expect_val("r0_ack", SIG_ACK, 16'h1);
    step();
    wr_en = 1'b0;
    step();

    // Branch with offset -1 word, then -512 words (wraps)
    branch_en = 1'b1; pc_offset = 10'h3FF; en_pc_2 = 1'b1;
    expect_val("br1_stage", SIG_STG, 16'h0010);
    step();
    en_pc_2 = 1'b0; pc_inc = 1'b1;
    expect_val("br1_pc", SIG_PC, 16'h0010);
    expect_val("br1_upd", SIG_UPD, 16'h1);
    step();
    pc_inc = 1'b0; pc_offset = 10'h200;
    step();
    en_pc_2 = 1'b1;
    expect_val("br2_stage", SIG_STG, 16'hFC12);
    step();
    en_pc_2 = 1'b0; pc_inc = 1'b1;
    expect_val("br2_pc", SIG_PC, 16'hFC12);
    step();
    pc_inc = 1'b0; branch_en = 1'b0;
    step();

    // Write-back held three cycles: one ack, no bypass
    src_reg = 4'd5; wr_reg = 4'd5; wr_data = 16'hBEEF; wr_en = 1'b1;
    #1;
    expect_val("wb_old", SIG_SRC, 16'h0000);
    drain();
    expect_val("wb_ack", SIG_ACK, 16'h1);
    expect_val("wb_new", SIG_SRC, 16'hBEEF);
    step();
    expect_val("wb_ack_once1", SIG_ACK, 16'h0);
    step();
    expect_val("wb_ack_once2", SIG_ACK, 16'h0);
    step();
    wr_en = 1'b0;
    step();

    // R3 write is discarded but acknowledged
    src_reg = 4'd3; wr_reg = 4'd3; wr_data = 16'h1234; wr_en = 1'b1;
    expect_val("r3_ack", SIG_ACK, 16'h1);
    expect_val("r3_zero", SIG_SRC, 16'h0000);
    step();
    wr_en = 1'b0;
    step();

    // R2 write overrides simultaneous flag update; then a flag-only update
    dst_reg = 4'd2; flag_we = 1'b1; flags_in = 4'b1011;
    wr_reg = 4'd2; wr_data = 16'h00F0; wr_en = 1'b1;
    expect_val("sr_wr_wins", SIG_DST, 16'h00F0);
    step();
    wr_en = 1'b0;
    expect_val("sr_flags", SIG_DST, 16'h01F3);
    step();
    flag_we = 1'b0;
    step();

    // Commit with nothing staged
    pc_inc = 1'b1;
    expect_val("err_pc", SIG_PC, 16'hFC12);
    expect_val("err_set", SIG_ERR, 16'h1);
    expect_val("err_noupd", SIG_UPD, 16'h0);
    step();
    pc_inc = 1'b0;
    step();

    // Reset discards a staged branch
    branch_en = 1'b1; pc_offset = 10'h3FF; en_pc_2 = 1'b1;
    step();
    en_pc_2 = 1'b0; rst = 1'b1;
    expect_val("rst2_pc", SIG_PC, 16'h0000);
    expect_val("rst2_err", SIG_ERR, 16'h0);
    expect_val("rst2_stg", SIG_STG, 16'h0000);
    step();
    rst = 1'b0; branch_en = 1'b0;
    step();
    pc_inc = 1'b1;
    expect_val("rst2_err_set", SIG_ERR, 16'h1);
    expect_val("rst2_pc_hold", SIG_PC, 16'h0000);
    step();
    pc_inc = 1'b0;
    step();

    // R0 write-back coinciding with a commit wins; FSM still returns to IDLE
    en_pc_2 = 1'b1;
    step();
    en_pc_2 = 1'b0; pc_inc = 1'b1; wr_reg = 4'd0; wr_data = 16'h1235; wr_en = 1'b1;
    expect_val("wrpc_pc", SIG_PC, 16'h1234);
    expect_val("wrpc_noupd", SIG_UPD, 16'h0);
    expect_val("wrpc_ack", SIG_ACK, 16'h1);
    step();
    pc_inc = 1'b0; wr_en = 1'b0;
    step();
    pc_inc = 1'b1;
    expect_val("wrpc_idle_pc", SIG_PC, 16'h1234);
    expect_val("wrpc_idle_upd", SIG_UPD, 16'h0);
    step();
    pc_inc = 1'b0;
    step();
    @(negedge clk);

    check_val("upd_pulses", 16'(upd_cnt), 16'd5);
    check_val("ack_pulses", 16'(ack_cnt), 16'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
